// File: rtl/tv_fx_scanline.sv
// Scanline/ghosting effect: on one line in every line_period lines, dim, delay, or delay+dim the pixel stream.
// Latency 1 cycle (pass/dim) or delay+1 cycles (delay modes); no backpressure. Optional macro TVFX_BLEND_EN.
module tv_fx_scanline #(
    parameter int CH        = 3,
    parameter int CW        = 8,
    parameter int DELAY_MAX = 8,
    parameter int DSW       = 3,
    parameter int LCW       = 4
) (
    input  logic                pixclk,
    input  logic                rst,
    input  logic                hs,
    input  logic                vs,
    input  logic [1:0]          mode,
    input  logic [2:0]          dim_shift,
    input  logic [DSW-1:0]      delay_sel,
    input  logic [LCW-1:0]      line_period,
    input  logic [CH*CW-1:0]    vid_pData_in,
    output logic [CH*CW-1:0]    vid_pData_out
);
    localparam int PW = CH * CW;
    localparam logic [LCW-1:0] LCW_ONE = LCW'(1);

    logic           hs_d;
    logic           hs_rise;
    logic           active;
    logic [LCW-1:0] line_cnt;
    logic [LCW-1:0] lp_q;
    logic [1:0]     mode_q;
    logic [2:0]     shift_q;
    logic [DSW-1:0] dsel_q;
    logic [PW-1:0]  dly [DELAY_MAX];
    logic [PW-1:0]  tap;
    logic [PW-1:0]  nxt;

    function automatic logic [PW-1:0] dim_px(input logic [PW-1:0] px, input logic [2:0] sh);
        logic [PW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++)
            r[c*CW +: CW] = px[c*CW +: CW] >> sh;
        return r;
    endfunction

`ifdef TVFX_BLEND_EN
    function automatic logic [PW-1:0] blend_px(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] r;
        logic [CW:0]   s;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            s = {1'b0, a[c*CW +: CW]} + {1'b0, b[c*CW +: CW]};
            r[c*CW +: CW] = s[CW:1];
        end
        return r;
    endfunction
`endif

    assign hs_rise = hs & ~hs_d;
    assign active  = (lp_q != '0) && (line_cnt == lp_q - LCW_ONE);

    // The counter compares against the period being latched on this same edge,
    // so line_cnt and lp_q always describe the same line once the edge is past.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            hs_d     <= 1'b0;
            line_cnt <= '0;
        end else begin
            hs_d <= hs;
            if (vs)
                line_cnt <= '0;
            else if (hs_rise) begin
                if (line_cnt >= line_period - LCW_ONE)
                    line_cnt <= '0;
                else
                    line_cnt <= line_cnt + LCW_ONE;
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            lp_q    <= '0;
            mode_q  <= 2'b00;
            shift_q <= '0;
            dsel_q  <= '0;
        end else if (hs_rise) begin
            lp_q    <= line_period;
            mode_q  <= mode;
            shift_q <= dim_shift;
            dsel_q  <= delay_sel;
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            for (int k = 0; k < DELAY_MAX; k++)
                dly[k] <= '0;
        end else begin
            dly[0] <= vid_pData_in;
            for (int k = 1; k < DELAY_MAX; k++)
                dly[k] <= dly[k-1];
        end
    end

    // Out-of-range selects fall through to the last stage.
    always_comb begin
        tap = dly[DELAY_MAX-1];
        for (int k = 0; k < DELAY_MAX - 1; k++)
            if (dsel_q == DSW'(k))
                tap = dly[k];
    end

    always_comb begin
        nxt = vid_pData_in;
        if (active) begin
            case (mode_q)
                2'b01:   nxt = dim_px(vid_pData_in, shift_q);
                2'b10:   nxt = tap;
`ifdef TVFX_BLEND_EN
                2'b11:   nxt = blend_px(vid_pData_in, tap);
`else
                2'b11:   nxt = dim_px(tap, shift_q);
`endif
                default: nxt = vid_pData_in;
            endcase
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst)
            vid_pData_out <= '0;
        else
            vid_pData_out <= nxt;
    end

endmodule

// File: tb/tb_tv_fx_scanline.sv
// Bench for tv_fx_scanline: line-level reference model checked every cycle plus literal spot checks.
module tb_tv_fx_scanline;
    localparam int CH = 3;
    localparam int CW = 8;
    localparam int DELAY_MAX = 8;
    localparam int DSW = 3;
    localparam int LCW = 4;
    localparam int PW = CH * CW;

    logic           pixclk = 1'b0;
    logic           rst;
    logic           hs;
    logic           vs;
    logic [1:0]     mode;
    logic [2:0]     dim_shift;
    logic [DSW-1:0] delay_sel;
    logic [LCW-1:0] line_period;
    logic [PW-1:0]  vid_pData_in;
    logic [PW-1:0]  vid_pData_out;

    int n_checks = 0;
    int n_fail   = 0;

    tv_fx_scanline #(.CH(CH), .CW(CW), .DELAY_MAX(DELAY_MAX), .DSW(DSW), .LCW(LCW)) dut (
        .pixclk(pixclk), .rst(rst), .hs(hs), .vs(vs), .mode(mode), .dim_shift(dim_shift),
        .delay_sel(delay_sel), .line_period(line_period),
        .vid_pData_in(vid_pData_in), .vid_pData_out(vid_pData_out)
    );

    always #5 pixclk = ~pixclk;

    // Reference model: lines counted since the last vs (or reset); a line is
    // active when its index modulo the period is period-1.
    logic [PW-1:0] hist [$];
    logic [PW-1:0] exp_out;
    bit            have_exp = 0;
    bit            m_hs;
    int            m_lines;
    int            m_lp, m_mode, m_shift, m_dsel;

    function automatic logic [PW-1:0] m_dim(input logic [PW-1:0] p, input int sh);
        logic [PW-1:0] r;
        for (int c = 0; c < CH; c++)
            r[c*CW +: CW] = CW'(int'(p[c*CW +: CW]) / (1 << sh));
        return r;
    endfunction

    function automatic logic [PW-1:0] m_avg(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] r;
        for (int c = 0; c < CH; c++)
            r[c*CW +: CW] = CW'((int'(a[c*CW +: CW]) + int'(b[c*CW +: CW])) / 2);
        return r;
    endfunction

    always @(negedge pixclk) begin
        int d;
        bit act;
        logic [PW-1:0] tp;
        if (have_exp) begin
            n_checks++;
            if (vid_pData_out !== exp_out) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t out=%h expected=%h", $time, vid_pData_out, exp_out);
            end
        end
        if (rst) begin
            exp_out = '0;
            m_hs = 0; m_lines = 0; m_lp = 0; m_mode = 0; m_shift = 0; m_dsel = 0;
            hist.delete();
            for (int i = 0; i < DELAY_MAX; i++) hist.push_back('0);
        end else begin
            act = (m_lp != 0) && ((m_lines % m_lp) == m_lp - 1);
            d = m_dsel + 1;
            if (d > DELAY_MAX) d = DELAY_MAX;
            tp = hist[d-1];
            if (!act || m_mode == 0) exp_out = vid_pData_in;
            else if (m_mode == 1)    exp_out = m_dim(vid_pData_in, m_shift);
            else if (m_mode == 2)    exp_out = tp;
            else begin
`ifdef TVFX_BLEND_EN
                exp_out = m_avg(vid_pData_in, tp);
`else
                exp_out = m_dim(tp, m_shift);
`endif
            end
            if (vs) m_lines = 0;
            else if (hs && !m_hs) m_lines++;
            if (hs && !m_hs) begin
                m_lp = int'(line_period); m_mode = int'(mode);
                m_shift = int'(dim_shift); m_dsel = int'(delay_sel);
            end
            m_hs = hs;
            hist.push_front(vid_pData_in);
            void'(hist.pop_back());
        end
        have_exp = 1;
    end

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic hs_pulse();
        hs = 1'b1; tick(); tick();
        hs = 1'b0; tick();
    endtask

    task automatic vs_pulse();
        vs = 1'b1; tick(); tick();
        vs = 1'b0; tick();
    endtask

    task automatic lit(input string name, input logic [PW-1:0] expv);
        n_checks++;
        if (vid_pData_out !== expv) begin
            n_fail++;
            $display("FAIL %s out=%h expected=%h", name, vid_pData_out, expv);
        end
    endtask

    initial begin
        rst = 1'b1; hs = 1'b0; vs = 1'b0; mode = 2'b00; dim_shift = 3'd0;
        delay_sel = '0; line_period = '0; vid_pData_in = 24'hFFFFFF;

        // 1: reset holds output at zero, then output follows input
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("reset_zero", 24'h000000);
        end
        rst = 1'b0;
        tick();
        lit("reset_release", 24'hFFFFFF);

        // 2: period 2, dim by 1, odd lines after vs are active
        line_period = 4'd2; mode = 2'b01; dim_shift = 3'd1; vid_pData_in = 24'hFF80FF;
        vs_pulse();
        for (int l = 1; l <= 4; l++) begin
            hs_pulse();
            run(3);
            lit(l % 2 == 1 ? "dim_active_line" : "dim_idle_line",
                l % 2 == 1 ? 24'h7F407F : 24'hFF80FF);
        end

        // 3: delay taps (line 5 active)
        mode = 2'b10; delay_sel = 3'd2;
        hs_pulse();
        for (int i = 1; i <= 12; i++) begin
            vid_pData_in = PW'(i);
            tick();
            if (i == 10) lit("delay_lag4", 24'h000007);
        end
        delay_sel = 3'd7;
        hs_pulse();
        hs_pulse();
        for (int i = 1; i <= 20; i++) begin
            vid_pData_in = PW'(32'h100 + i);
            tick();
            if (i == 20) lit("delay_lag9", 24'h00010C);
        end

        // 4: mid-line mode change waits for the next line
        mode = 2'b00; vid_pData_in = 24'hFF80FF;
        hs_pulse();
        hs_pulse();
        mode = 2'b01;
        run(4);
        lit("midline_no_tear", 24'hFF80FF);
        hs_pulse();
        run(3);
        lit("after_change_idle", 24'hFF80FF);
        hs_pulse();
        run(3);
        lit("after_change_active", 24'h7F407F);

        // 5: vs wins over a coincident hs rise; period 0 is plain pass-through
        vs = 1'b1; hs = 1'b1; tick();
        vs = 1'b0; tick();
        hs = 1'b0; tick();
        hs_pulse();
        run(2);
        lit("vs_priority", 24'h7F407F);
        line_period = 4'd0; mode = 2'b11;
        hs_pulse();
        vid_pData_in = 24'h123456; tick();
        lit("period0_pass_a", 24'h123456);
        vid_pData_in = 24'hABCDEF; tick();
        lit("period0_pass_b", 24'hABCDEF);

        // 6: mode 11 with 1-pixel delay, every line active
        vs_pulse();
        line_period = 4'd1; mode = 2'b11; dim_shift = 3'd1; delay_sel = 3'd0;
        hs_pulse();
        for (int i = 0; i < 8; i++) begin
            vid_pData_in = (i % 2 == 1) ? 24'hFEFEFE : 24'h000000;
            tick();
`ifdef TVFX_BLEND_EN
            if (i >= 2) lit("blend_avg", 24'h7F7F7F);
`else
            if (i >= 2) lit("delay_dim", (i % 2 == 1) ? 24'h000000 : 24'h7F7F7F);
`endif
        end
        mode = 2'b01; dim_shift = 3'd4; vid_pData_in = 24'hFFFFFF;
        hs_pulse();
        tick();
        lit("dim4_no_cross", 24'h0F0F0F);
        dim_shift = 3'd7;
        hs_pulse();
        tick();
        lit("dim7", 24'h010101);

        // Random controls and pixels over one frame at period 3
        vs_pulse();
        line_period = 4'd3;
        for (int l = 0; l < 6; l++) begin
            mode = 2'($urandom_range(0, 3));
            dim_shift = 3'($urandom_range(0, 7));
            delay_sel = DSW'($urandom_range(0, 7));
            hs_pulse();
            for (int i = 0; i < 20; i++) begin
                vid_pData_in = PW'($urandom);
                tick();
            end
        end

        // Reset mid-line ends the active line
        rst = 1'b1; tick();
        lit("midline_reset", 24'h000000);
        rst = 1'b0;
        vid_pData_in = 24'h5A5A5A; tick();
        lit("post_reset_pass", 24'h5A5A5A);
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tv_fx_scanline.md
Name: tv_fx_scanline

Overview:
Parametrised scanline/ghosting effect for the video_fx chain, placed between pixel source and output encoder on the pixclk domain. It processes one line in every N lines (N selectable at run time). On those lines it dims the pixels, substitutes a delayed copy of them, or both, with the delay tap selectable. Line and frame timing come from hs and vs edges detected synchronously on pixclk. hs is not used as a clock.

Parameters:
CH, 3, number of colour channels packed in the pixel bus, channel 0 in the LSBs
CW, 8, bits per channel
DELAY_MAX, 8, depth of the per-channel pixel delay line (>=1)
DSW, 3, width of delay_sel (2**DSW >= DELAY_MAX)
LCW, 4, width of line_period and the internal line counter

Ports:
pixclk  in  1  pixel clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
hs  in  1  horizontal sync, active high, synchronous to pixclk
vs  in  1  vertical sync, active high, synchronous to pixclk
mode  in  2  00 pass, 01 dim, 10 delay, 11 delay+dim
dim_shift  in  3  per-channel right-shift amount for dim modes
delay_sel  in  DSW  delay tap; delay = min(delay_sel+1, DELAY_MAX) pixels
line_period  in  LCW  0 = effect off; N = effect on one line in N
vid_pData_in  in  CH*CW  pixel data in
vid_pData_out  out  CH*CW  pixel data out, registered

Behaviour:
- Reset: vid_pData_out=0, hs_d=0, line_cnt=0, latched controls=0 (mode 00), every delay-line stage=0. Reset mid-line takes effect on the next edge and ends any active line.
- hs_rise = hs & ~hs_d; hs_d is a 1-cycle register of hs.
- Line counter:
  - While vs=1: line_cnt<=0 every cycle; vs has priority over a simultaneous hs_rise.
  - Else, on hs_rise: if line_cnt >= line_period-1 then line_cnt<=0, otherwise line_cnt<=line_cnt+1.
  - line_period=1 gives every line active.
- active = (line_period!=0) & (line_cnt == line_period-1), using the latched line_period. With period 2, the first hs after vs makes that line active, then every second line after it.
- Control latching: mode, dim_shift, delay_sel and line_period are latched on hs_rise (and on reset) only. A change mid-line takes effect from the next line, so there is no tearing.
- Delay line:
  - One shift register per channel, DELAY_MAX stages, shifting every cycle regardless of mode.
  - tap[k] is the input from k+1 cycles earlier.
  - Selected tap = min(delay_sel+1, DELAY_MAX); an out-of-range delay_sel clamps to the last stage.
- Dim: per-channel logical right shift by dim_shift, zero-filled within each CW-bit channel. No bit crosses a channel boundary. dim_shift>=CW gives 0.
- Output register, updated every cycle:
  - If !active, or latched mode=00: out <= vid_pData_in (1-cycle latency).
  - 01: out <= dim(vid_pData_in).
  - 10: out <= tap.
  - 11: out <= dim(tap).
- Latency: 1 cycle for pass/dim; delay+1 cycles from input to output for delay modes.
- Activation takes effect the cycle after the hs_rise register update, i.e. 2 cycles after the hs rising edge at the input.

Optional Feature:
Macro TVFX_BLEND_EN.
- Defined: mode 11 outputs the per-channel average of the current input and the tap, (in+tap)>>1, computed with a CW+1-bit sum; dim_shift is ignored in this mode.
- Undefined: mode 11 is dim(tap) as above.
- Modes 00/01/10 are identical in both builds.

Test Plan:
1. rst=1 for 3 cycles with input 0xFFFFFF -> output 0x000000 throughout; 1 cycle after rst falls, output follows input.
2. line_period=2, mode=01, dim_shift=1, input constant 0xFF80FF, pulse vs then 4 hs pulses -> lines 1 and 3 output 0x7F407F, lines 0 and 2 output 0xFF80FF; never 0x7FC07F (no cross-channel bit).
3. mode=10, delay_sel=2, active line, input a ramp 0x000001,0x000002,... -> output lags input by 4 cycles (3 delay + 1 register); delay_sel=7 with DELAY_MAX=8 gives lag 9.
4. mode changed from 00 to 01 mid-active-line -> output unchanged until the next hs rising edge, dimmed on the following active line.
5. hs rising in the same cycle as vs=1 -> line_cnt stays 0; line_period=0 -> output always equals input delayed 1 cycle.
6. With TVFX_BLEND_EN, mode=11, delay 1, input alternating 0x000000/0xFEFEFE on an active line -> output 0x7F7F7F; without the macro and with dim_shift=1 -> alternating 0x7F7F7F/0x000000.
